dtcm_arbiter: RTL

- Shares the single-port data TCM between two requesters: the CPU load/store port and an external port used by the loader, debug or DMA.
- The CPU has priority by default. A starvation counter and an external burst lock guarantee the external port forward progress.
- Sits between `cpu.execution`'s memory stage and `dtcm`, replacing the direct connection.
- TCM read latency is one cycle.

---
 rtl/tcm_pkg.sv | 18 +
 rtl/dtcm_arbiter_if.sv | 52 +++++
 rtl/tcm_req_mux.sv | 32 +++
 rtl/dtcm_arbiter.sv | 99 +++++++++
 4 files changed

// File: rtl/tcm_pkg.sv
// Shared types and constants for the data TCM arbitration path.
// Carries the default geometry, the request payload layout and the port select encoding.
package tcm_pkg;

  localparam int AW = 14;
  localparam int DW = 32;

  localparam logic SEL_CPU = 1'b0;
  localparam logic SEL_EXT = 1'b1;

  typedef struct packed {
    logic              we;
    logic [DW/8-1:0]   be;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
  } tcm_req_t;

endpackage

// File: rtl/dtcm_arbiter_if.sv
// Signal bundle between the two TCM requesters, the arbiter and the TCM itself.
// The slave modport is the arbiter's view; master is everything around it.
interface dtcm_arbiter_if #(
  parameter int AW = tcm_pkg::AW,
  parameter int DW = tcm_pkg::DW
);

  logic            cpu_req;
  logic            cpu_we;
  logic [DW/8-1:0] cpu_be;
  logic [AW-1:0]   cpu_addr;
  logic [DW-1:0]   cpu_wdata;
  logic            cpu_gnt;
  logic            cpu_rvalid;
  logic [DW-1:0]   cpu_rdata;

  logic            ext_req;
  logic            ext_we;
  logic [DW/8-1:0] ext_be;
  logic [AW-1:0]   ext_addr;
  logic [DW-1:0]   ext_wdata;
  logic            ext_lock;
  logic            ext_gnt;
  logic            ext_rvalid;
  logic [DW-1:0]   ext_rdata;

  logic            mem_en;
  logic            mem_we;
  logic [DW/8-1:0] mem_be;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  ext_req, ext_we, ext_be, ext_addr, ext_wdata, ext_lock,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output ext_req, ext_we, ext_be, ext_addr, ext_wdata, ext_lock,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/tcm_req_mux.sv
// Steers the winning requester's payload onto the TCM and raises only that port's grant.
// An idle cycle drives an all-zero payload so the TCM never sees stray write enables.
module tcm_req_mux
  import tcm_pkg::*;
(
  input  tcm_req_t cpu_pl,
  input  tcm_req_t ext_pl,
  input  logic     sel,
  input  logic     valid,
  output tcm_req_t mem_pl,
  output logic     cpu_gnt,
  output logic     ext_gnt,
  output logic     mem_en
);

  always_comb begin
    mem_pl  = '0;
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    mem_en  = valid;
    if (valid) begin
      if (sel == SEL_EXT) begin
        mem_pl  = ext_pl;
        ext_gnt = 1'b1;
      end else begin
        mem_pl  = cpu_pl;
        cpu_gnt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dtcm_arbiter.sv
// Shares the single-port data TCM between the CPU memory stage and an external port.
// CPU wins by default; a starvation counter and a burst lock guarantee external progress.
module dtcm_arbiter
  import tcm_pkg::*;
#(
  parameter int AW         = tcm_pkg::AW,
  parameter int DW         = tcm_pkg::DW,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           reset,
  dtcm_arbiter_if.slave  bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  logic       lock_q;
  logic [1:0] rd_owner_q;

  logic       grant_valid;
  logic       grant_sel;
  logic       cpu_win;
  logic       ext_win;
  tcm_req_t   cpu_pl;
  tcm_req_t   ext_pl;
  tcm_req_t   mem_pl;

  assign cpu_pl = '{we: bus.cpu_we, be: bus.cpu_be[DW/8-1:0],
                    addr: bus.cpu_addr[AW-1:0], wdata: bus.cpu_wdata[DW-1:0]};
  assign ext_pl = '{we: bus.ext_we, be: bus.ext_be[DW/8-1:0],
                    addr: bus.ext_addr[AW-1:0], wdata: bus.ext_wdata[DW-1:0]};

  // A held lock owns the TCM outright, so the CPU stalls even when the external side idles.
  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = SEL_CPU;
    if (reset) begin
      grant_valid = 1'b0;
    end else if (lock_q) begin
      grant_valid = bus.ext_req;
      grant_sel   = SEL_EXT;
    end else if (bus.ext_req && (starve_cnt == STARVE_LIM)) begin
      grant_valid = 1'b1;
      grant_sel   = SEL_EXT;
    end else if (bus.cpu_req) begin
      grant_valid = 1'b1;
      grant_sel   = SEL_CPU;
    end else if (bus.ext_req) begin
      grant_valid = 1'b1;
      grant_sel   = SEL_EXT;
    end
  end

  tcm_req_mux u_mux (
    .cpu_pl  (cpu_pl),
    .ext_pl  (ext_pl),
    .sel     (grant_sel),
    .valid   (grant_valid),
    .mem_pl  (mem_pl),
    .cpu_gnt (cpu_win),
    .ext_gnt (ext_win),
    .mem_en  (bus.mem_en)
  );

  assign bus.cpu_gnt   = cpu_win;
  assign bus.ext_gnt   = ext_win;
  assign bus.mem_we    = mem_pl.we;
  assign bus.mem_be    = mem_pl.be;
  assign bus.mem_addr  = mem_pl.addr;
  assign bus.mem_wdata = mem_pl.wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 4'd0;
      lock_q     <= 1'b0;
      rd_owner_q <= 2'b00;
    end else begin
      if (cpu_win && bus.ext_req) begin
        if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
      end else if (ext_win || !bus.ext_req) begin
        starve_cnt <= 4'd0;
      end

      if (!bus.ext_lock)  lock_q <= 1'b0;
      else if (ext_win)   lock_q <= 1'b1;

      // Remember who issued the read so the next-cycle TCM data goes to the right port.
      if (grant_valid && !mem_pl.we) rd_owner_q <= {1'b1, grant_sel};
      else                           rd_owner_q[1] <= 1'b0;
    end
  end

  assign bus.cpu_rvalid = rd_owner_q[1] && (rd_owner_q[0] == SEL_CPU);
  assign bus.ext_rvalid = rd_owner_q[1] && (rd_owner_q[0] == SEL_EXT);
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.ext_rdata  = bus.mem_rdata;

endmodule
